md_issue_ctrl: RTL and testbench

//  E-stage front end for the MultDiv unit. Accepts mult/div/mf/mt ops from E-stage decode,

---
 rtl/md_pkg.sv | 47 ++++
 rtl/hilo_regs.sv | 38 +++
 rtl/md_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the MultDiv issue front end: E-stage MD op classes,
// MultDiv Op codes and the issue FSM states.
package md_pkg;

  localparam logic [3:0] MDC_NONE  = 4'd0;
  localparam logic [3:0] MDC_MULT  = 4'd1;
  localparam logic [3:0] MDC_MULTU = 4'd2;
  localparam logic [3:0] MDC_DIV   = 4'd3;
  localparam logic [3:0] MDC_DIVU  = 4'd4;
  localparam logic [3:0] MDC_MFHI  = 4'd5;
  localparam logic [3:0] MDC_MFLO  = 4'd6;
  localparam logic [3:0] MDC_MTHI  = 4'd7;
  localparam logic [3:0] MDC_MTLO  = 4'd8;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } md_state_e;

  function automatic logic md_is_arith(input logic [3:0] mdc);
    logic r;
    case (mdc)
      MDC_MULT, MDC_MULTU, MDC_DIV, MDC_DIVU: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] md_op_of(input logic [3:0] mdc);
    logic [1:0] r;
    case (mdc)
      MDC_MULT:  r = MD_MULT;
      MDC_MULTU: r = MD_MULTU;
      MDC_DIV:   r = MD_DIV;
      MDC_DIVU:  r = MD_DIVU;
      default:   r = MD_MULT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers. A MultDiv result writes both halves; MTHI/MTLO
// write one half from rs.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_md_we,
  input  logic             i_hi_rs_we,
  input  logic             i_lo_rs_we,
  input  logic [WIDTH-1:0] i_md_hi,
  input  logic [WIDTH-1:0] i_md_lo,
  input  logic [WIDTH-1:0] i_rs,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // HI/LO storage; md and rs writes are mutually exclusive by FSM state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (i_md_we) begin
      r_hi <= i_md_hi;
      r_lo <= i_md_lo;
    end else begin
      if (i_hi_rs_we) r_hi <= i_rs;
      if (i_lo_rs_we) r_lo <= i_rs;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage front end for MultDiv: launches ops, stalls E while the unit is busy,
// owns HI/LO and drops the result of an op flushed while in M.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [3:0]       i_e_op,
  input  logic [WIDTH-1:0] i_e_rs,
  input  logic [WIDTH-1:0] i_e_rt,
  input  logic             i_e_flush,
  input  logic             i_md_busy,
  input  logic [WIDTH-1:0] i_md_hi,
  input  logic [WIDTH-1:0] i_md_lo,
  output logic             o_md_start,
  output logic [1:0]       o_md_op,
  output logic [WIDTH-1:0] o_md_a,
  output logic [WIDTH-1:0] o_md_b,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_mf_data
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic             r_cancel;
  logic             w_cancel_nxt;
  logic             w_md_we;
  logic             w_accept;
  logic             w_mt_ok;
  logic             r_md_start;
  logic [1:0]       r_md_op;
  logic [WIDTH-1:0] r_md_a;
  logic [WIDTH-1:0] r_md_b;
  logic [WIDTH-1:0] w_mf_data;

  // Busy is checked in IDLE too, so nothing issues into a unit still running after reset
  assign o_stall  = !i_reset && (i_e_op != MDC_NONE) &&
                    ((r_state != ST_IDLE) || i_md_busy);
  assign w_accept = (r_state == ST_IDLE) && md_is_arith(i_e_op) && !i_e_flush && !o_stall;
  assign w_mt_ok  = (r_state == ST_IDLE) && !i_e_flush && !o_stall;

  // FSM state and cancel flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cancel <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
    end
  end

  // Next state; a flush in LAUNCH hits the issuing op itself, later flushes are younger
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_md_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_LAUNCH;
        else          w_state_nxt = ST_IDLE;
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_RUN;
        if (i_e_flush) w_cancel_nxt = 1'b1;
        else           w_cancel_nxt = r_cancel;
      end
      ST_RUN: begin
        if (!i_md_busy) begin
          w_state_nxt  = ST_IDLE;
          w_cancel_nxt = 1'b0;
          w_md_we      = !r_cancel;
        end else begin
          w_state_nxt  = ST_RUN;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cancel_nxt = 1'b0;
      end
    endcase
  end

  // Launch registers toward MultDiv
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_md_start <= 1'b0;
      r_md_op    <= MD_MULT;
      r_md_a     <= {WIDTH{1'b0}};
      r_md_b     <= {WIDTH{1'b0}};
    end else begin
      r_md_start <= w_accept;
      if (w_accept) begin
        r_md_op <= md_op_of(i_e_op);
        r_md_a  <= i_e_rs;
        r_md_b  <= i_e_rt;
      end
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_md_we    (w_md_we),
    .i_hi_rs_we (w_mt_ok && (i_e_op == MDC_MTHI)),
    .i_lo_rs_we (w_mt_ok && (i_e_op == MDC_MTLO)),
    .i_md_hi    (i_md_hi),
    .i_md_lo    (i_md_lo),
    .i_rs       (i_e_rs),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  // MF read port, no bypass of same-cycle writes
  always_comb begin
    w_mf_data = {WIDTH{1'b0}};
    case (i_e_op)
      MDC_MFHI: w_mf_data = o_hi;
      MDC_MFLO: w_mf_data = o_lo;
      default:  w_mf_data = {WIDTH{1'b0}};
    endcase
  end

  assign o_md_start = r_md_start;
  assign o_md_op    = r_md_op;
  assign o_md_a     = r_md_a;
  assign o_md_b     = r_md_b;
  assign o_mf_data  = w_mf_data;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl with a behavioural MultDiv and a transaction-level
// model of the issue/HI-LO rules checked every cycle, plus literal pins.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   e_op = MDC_NONE;
  logic [W-1:0] e_rs = 32'h0;
  logic [W-1:0] e_rt = 32'h0;
  logic         e_flush = 1'b0;
  logic         md_busy;
  logic [W-1:0] md_hi = 32'h0;
  logic [W-1:0] md_lo = 32'h0;
  logic         md_start;
  logic [1:0]   md_op;
  logic [W-1:0] md_a, md_b, hi, lo, mf_data;
  logic         stall;

  int n_cmp = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_e_op(e_op), .i_e_rs(e_rs), .i_e_rt(e_rt),
    .i_e_flush(e_flush), .i_md_busy(md_busy), .i_md_hi(md_hi), .i_md_lo(md_lo),
    .o_md_start(md_start), .o_md_op(md_op), .o_md_a(md_a), .o_md_b(md_b),
    .o_stall(stall), .o_hi(hi), .o_lo(lo), .o_mf_data(mf_data)
  );

  // Behavioural MultDiv: BUSY from the cycle after start; never reset by the core
  function automatic logic [63:0] md_calc(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    int q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (op == 2'b00) return 64'(sa * sb);
    if (op == 2'b01) return ua * ub;
    if (b == 32'h0) return 64'h0;
    if (op == 2'b10) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  int unsigned bz_cnt = 0;
  assign md_busy = (bz_cnt != 0);
  always @(posedge clk) begin
    if (md_start) begin
      bz_cnt <= md_op[1] ? 8 : 4;
      {md_hi, md_lo} <= md_calc(md_op, md_a, md_b);
    end else if (bz_cnt != 0) begin
      bz_cnt <= bz_cnt - 1;
    end
  end

  // Transaction model: one op in flight, aged in cycles since acceptance
  logic         m_inflight = 1'b0, m_cancel = 1'b0, m_start = 1'b0;
  int           m_age = 0;
  logic [1:0]   m_op = 2'b00;
  logic [W-1:0] m_a = 32'h0, m_b = 32'h0, m_hi = 32'h0, m_lo = 32'h0;

  function automatic logic is_arith(input logic [3:0] op);
    return op == MDC_MULT || op == MDC_MULTU || op == MDC_DIV || op == MDC_DIVU;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_inflight <= 1'b0; m_cancel <= 1'b0; m_start <= 1'b0; m_age <= 0;
      m_op <= 2'b00; m_a <= 32'h0; m_b <= 32'h0; m_hi <= 32'h0; m_lo <= 32'h0;
    end else begin
      m_start <= 1'b0;
      if (!m_inflight) begin
        if (is_arith(e_op) && !e_flush && !md_busy) begin
          m_inflight <= 1'b1; m_age <= 1; m_cancel <= 1'b0; m_start <= 1'b1;
          m_a <= e_rs; m_b <= e_rt;
          m_op <= (e_op == MDC_MULT) ? 2'b00 : (e_op == MDC_MULTU) ? 2'b01 :
                  (e_op == MDC_DIV) ? 2'b10 : 2'b11;
        end else if (!e_flush && !md_busy && e_op == MDC_MTHI) begin
          m_hi <= e_rs;
        end else if (!e_flush && !md_busy && e_op == MDC_MTLO) begin
          m_lo <= e_rs;
        end
      end else begin
        m_age <= m_age + 1;
        if (m_age == 1 && e_flush) m_cancel <= 1'b1;
        if (m_age >= 2 && !md_busy) begin
          m_inflight <= 1'b0;
          if (!m_cancel) begin
            m_hi <= md_hi;
            m_lo <= md_lo;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall", 32'(stall),
            32'(!reset && e_op != MDC_NONE && (m_inflight || md_busy)));
      check("md_start", 32'(md_start), 32'(m_start));
      check("md_op", 32'(md_op), 32'(m_op));
      check("md_a", md_a, m_a);
      check("md_b", md_b, m_b);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("mf_data", mf_data,
            (e_op == MDC_MFHI) ? m_hi : (e_op == MDC_MFLO) ? m_lo : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       input logic fl);
    e_op = op; e_rs = rs; e_rt = rt; e_flush = fl;
  endtask

  // Hold the current E op until it is not stalled, then let it go through one edge
  task automatic hold(output logic [W-1:0] mf_at_release);
    bit done = 0;
    mf_at_release = 32'h0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!stall) begin
        mf_at_release = mf_data;
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL hold_timeout at %0t: stall still %b", $time, stall);
    end
    step();
    e_op = MDC_NONE; e_flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!m_inflight && !md_busy) done = 1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout at %0t: busy %b", $time, md_busy);
    end
    step();
  endtask

  logic [W-1:0] mf;

  initial begin
    step();
    cmp_en = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_start", 32'(md_start), 32'h0);
    check("rst_op", 32'(md_op), 32'h0);
    step();

    // MULT signed
    drive(MDC_MULT, 32'h7fffffff, 32'hffffffff, 1'b0); hold(mf); wait_idle();
    @(negedge clk);
    check("mult_hi", hi, 32'hffffffff);
    check("mult_lo", lo, 32'h80000001);
    step();

    // Arith op flushed in E is never accepted
    drive(MDC_MULT, 32'h1, 32'h2, 1'b1); step(); drive(MDC_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("flushed_no_start", 32'(md_start), 32'h0);
    step();

    // MULTU then MFHI held behind it
    drive(MDC_MULTU, 32'h7fffffff, 32'hffffffff, 1'b0); hold(mf);
    drive(MDC_MFHI, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mfhi_stalls", 32'(stall), 32'h1);
    hold(mf);
    check("mfhi_data", mf, 32'h7ffffffe);
    wait_idle();

    // DIV signed, then DIV followed by DIVU in the next cycle
    drive(MDC_DIV, 32'd7, 32'hfffffffe, 1'b0); hold(mf); wait_idle();
    @(negedge clk);
    check("div_lo", lo, 32'hfffffffd);
    check("div_hi", hi, 32'h1);
    step();
    drive(MDC_DIV, 32'd9, 32'd4, 1'b0); hold(mf);
    drive(MDC_DIVU, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    check("divu_stalls", 32'(stall), 32'h1);
    hold(mf); wait_idle();
    @(negedge clk);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    step();

    // MTHI, then MTLO flushed
    drive(MDC_MTHI, 32'h12345678, 32'h0, 1'b0); step();
    drive(MDC_MFHI, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mthi_visible", mf_data, 32'h12345678);
    step();
    drive(MDC_MTLO, 32'haaaa5555, 32'h0, 1'b1); step();
    drive(MDC_MFLO, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mtlo_flushed", mf_data, 32'd14);
    step();
    drive(MDC_NONE, 32'h0, 32'h0, 1'b0);

    // Flush in LAUNCH cancels; flush in RUN does not
    drive(MDC_MULT, 32'd3, 32'd5, 1'b0); hold(mf);
    e_flush = 1'b1; step(); e_flush = 1'b0;
    wait_idle();
    @(negedge clk);
    check("cancel_hi", hi, 32'h12345678);
    check("cancel_lo", lo, 32'd14);
    step();
    drive(MDC_MULT, 32'd3, 32'd5, 1'b0); hold(mf);
    step(); e_flush = 1'b1; step(); e_flush = 1'b0;
    wait_idle();
    @(negedge clk);
    check("runflush_hi", hi, 32'h0);
    check("runflush_lo", lo, 32'd15);
    step();

    // Reset while the op is running
    drive(MDC_MULT, 32'd6, 32'd7, 1'b0); hold(mf);
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    drive(MDC_MFLO, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("rrun_hi", hi, 32'h0);
    check("rrun_lo", lo, 32'h0);
    check("rrun_start", 32'(md_start), 32'h0);
    check("rrun_stall", 32'(stall), 32'h1);
    hold(mf);
    check("rrun_mf", mf, 32'h0);
    wait_idle();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
